// File: rtl/chess_clock_dual.sv
// chess_clock_dual: two-player chess clock with per-player BCD mm:ss budgets.
// Only the side to move counts down, one second per prescaler wrap. Supports a
// Fischer increment on each move, run/pause via the flag level, sticky per-player
// timeout flags and a new-game reload. Four seven-segment digits per player are
// decoded straight from the budget registers.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   flag          run/pause level (1 = run, 0 = pause)
//   move_done     one-cycle pulse: the active player completed a move
//   new_game      one-cycle pulse: reload both budgets and return to IDLE
//   active_player 0 = player A to move, 1 = player B
//   running       high only while the clock is counting (state RUN)
//   timeout       bit0 = A flagged, bit1 = B flagged (sticky)
//   seg_a, seg_b  {min_tens, min_units, sec_tens, sec_units}, 7 bits each,
//                 bit0 = segment a .. bit6 = segment g
module chess_clock_dual #(
  parameter int TICK_DIV       = 50000000,
  parameter int START_MIN      = 5,
  parameter int START_SEC      = 0,
  parameter int INC_SEC        = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flag,
  input  logic        move_done,
  input  logic        new_game,
  output logic        active_player,
  output logic        running,
  output logic [1:0]  timeout,
  output logic [27:0] seg_a,
  output logic [27:0] seg_b
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] START_BCD = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                       4'(START_SEC / 10), 4'(START_SEC % 10)};
  localparam logic [6:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t            state_reg, state_next;
  logic [1:0][15:0]  budget_reg, budget_next;
  logic [PW-1:0]     presc_reg, presc_next;
  logic              active_reg, active_next;
  logic [1:0]        timeout_reg, timeout_next;

  logic [15:0] cur_budget;
  logic [15:0] dec_budget;
  logic [15:0] tick_budget;
  logic        tick;

  // One-second BCD decrement; only used when the budget is non-zero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    if (b[3:0] != 4'd0) begin
      r[3:0] = b[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (b[7:4] != 4'd0) begin
        r[7:4] = b[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (b[11:8] != 4'd0) begin
          r[11:8] = b[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = b[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Adds the increment with carry from seconds into minutes, saturating at 99:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] b);
    int s;
    int m;
    s = int'(b[7:4]) * 10 + int'(b[3:0]) + INC_SEC;
    m = int'(b[15:12]) * 10 + int'(b[11:8]);
    if (s >= 60) begin
      s = s - 60;
      m = m + 1;
    end
    if (m > 99) begin
      return 16'h9959;
    end
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;  // invalid BCD stays blank
    endcase
    return s;
  endfunction

  assign cur_budget  = budget_reg[active_reg];
  assign dec_budget  = bcd_dec(cur_budget);
  assign tick        = (presc_reg == PRESC_MAX);
  assign tick_budget = tick ? dec_budget : cur_budget;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      budget_reg  <= {START_BCD, START_BCD};
      presc_reg   <= '0;
      active_reg  <= 1'b0;
      timeout_reg <= 2'b00;
    end else begin
      state_reg   <= state_next;
      budget_reg  <= budget_next;
      presc_reg   <= presc_next;
      active_reg  <= active_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    budget_next  = budget_reg;
    presc_next   = presc_reg;
    active_next  = active_reg;
    timeout_next = timeout_reg;

    if (new_game) begin
      state_next   = IDLE;
      budget_next  = {START_BCD, START_BCD};
      presc_next   = '0;
      active_next  = 1'b0;
      timeout_next = 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          // A's opening move hands the clock to B without any increment.
          if (move_done) begin
            active_next = 1'b1;
            state_next  = flag ? RUN : PAUSED;
          end
        end
        RUN: begin
          if (!flag) begin
            state_next = PAUSED;
          end else if (cur_budget == 16'h0000) begin
            // Entered RUN with an empty budget: flag without waiting for a tick.
            timeout_next[active_reg] = 1'b1;
            state_next               = EXPIRED;
          end else if (tick && (dec_budget == 16'h0000)) begin
            // Running out beats a move landing on the same edge.
            budget_next[active_reg]  = dec_budget;
            timeout_next[active_reg] = 1'b1;
            presc_next               = '0;
            state_next               = EXPIRED;
          end else if (move_done) begin
            // Decrement (if any) first, then the increment, on the outgoing side.
            budget_next[active_reg] = bcd_inc(tick_budget);
            active_next             = ~active_reg;
            presc_next              = '0;
          end else begin
            budget_next[active_reg] = tick_budget;
            presc_next              = tick ? '0 : presc_reg + 1'b1;
          end
        end
        PAUSED: begin
          if (flag) begin
            state_next = RUN;
          end
        end
        EXPIRED: begin
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign active_player = active_reg;
  assign running       = (state_reg == RUN);
  assign timeout       = timeout_reg;

  // Digit gi of each player sits at budget bits [4*gi +: 4] and seg bits [7*gi +: 7].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_seg
      assign seg_a[gi*7 +: 7] = seg7(budget_reg[0][gi*4 +: 4]) ^ SEG_MASK;
      assign seg_b[gi*7 +: 7] = seg7(budget_reg[1][gi*4 +: 4]) ^ SEG_MASK;
    end
  endgenerate

endmodule

// File: doc/chess_clock_dual.md
Name: chess_clock_dual

Overview:
Two-player chess clock, the parametrised successor of the single countdown timer. Holds a separate BCD mm:ss budget per player and counts down only the side to move. Supports Fischer increment, a pause control, timeout flags and new-game reload. Drives four seven-segment digits per player, directly to board displays.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (>=2)
START_MIN, 5, initial minutes per player (0-99)
START_SEC, 0, initial seconds per player (0-59)
INC_SEC, 0, seconds added to the mover on each move_done (0-59)
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (common-anode)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
flag  in  1  run/pause level: 1 = run, 0 = pause
move_done  in  1  one-cycle pulse: active player completed a move
new_game  in  1  one-cycle pulse: reload both budgets, go to IDLE
active_player  out  1  0 = player A to move, 1 = player B
running  out  1  1 while state RUN
timeout  out  2  bit0 = A flagged, bit1 = B flagged; sticky
seg_a  out  28  player A digits {min_tens, min_units, sec_tens, sec_units}, 7 bits each, bit0 = a .. bit6 = g
seg_b  out  28  player B digits, same format

Behaviour:
- Reset (reset low, async): state IDLE; both budgets = START_MIN:START_SEC; prescaler = 0; active_player = 0; running = 0; timeout = 0. seg_a/seg_b immediately show the start time.
- Budgets are held as four BCD digits per player. Minutes are 00-99; seconds tens are 0-5.
- State IDLE: leave on first move_done (A's opening move). active_player becomes 1, no increment is applied, and the state goes to RUN if flag = 1, else PAUSED. flag alone does not start the clock.
- State RUN: the prescaler counts 0..TICK_DIV-1. When it wraps, a one-cycle tick decrements the active budget by one second with BCD borrow (xx:00 -> (xx-1):59; m0:00 -> (m-1)9:59).
  - flag = 0 -> PAUSED. The prescaler holds its value.
- State PAUSED: budgets and prescaler frozen; move_done ignored; flag = 1 -> RUN.
- move_done in RUN:
  - Adds INC_SEC to the mover's budget with BCD carry. The result saturates at 99:59.
  - Toggles active_player.
  - Clears the prescaler to 0, so a fresh second starts for the new side.
  - Takes effect on the next edge.
- Tick and move_done in the same cycle: apply the tick decrement first, then the increment, to the outgoing player. If the decrement reaches 00:00, timeout wins and the move is discarded.
- Expiry: when the active budget becomes 00:00 on a tick, set that player's timeout bit and go to EXPIRED. A budget already at 00:00 when RUN is entered expires on the next cycle without a tick.
- State EXPIRED: everything frozen; running = 0; only new_game or reset leave it.
- new_game, from any state: both budgets reloaded, timeout cleared, prescaler cleared, active_player = 0, state IDLE. new_game has priority over every other input in the same cycle.
- running = 1 only in RUN. All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- Seven-segment decode is 0-9 only; invalid BCD shows blank. SEG_ACTIVE_LOW inverts all 56 segment bits.
- Inputs are assumed synchronous to clk; debounce is external.

Test Plan:
1. TICK_DIV=4, START 0:05, reset, flag=1, no move -> stays IDLE; seg_a/seg_b show 00:05; running=0.
2. flag=1, move_done -> active_player=1, running=1. After 8 cycles B = 00:03 and A still 00:05. Next move_done -> active_player=0, A starts decrementing.
3. INC_SEC=3, START 0:58: A moves at 00:57 -> A = 01:00, crossing the BCD carry. START 99:58 with INC 3 -> saturates at 99:59.
4. START 0:02, B runs out -> after 2 ticks timeout=2'b10, state EXPIRED. Further ticks, move_done and flag toggles do not change any output. new_game -> 00:02/00:02, timeout=0, IDLE.
5. flag=0 mid-second at prescaler=2: hold 20 cycles, budgets unchanged. flag=1: the tick lands 2 cycles later.
6. Tick coincident with move_done at B = 00:01 -> timeout[1]=1, active_player stays 1. Separately, reset asserted mid-RUN -> immediate return to all reset values without waiting for a clk edge.
